// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: buffers multi-cycle register write-backs, drains them to the single write port when the ALU path is idle, and flags rs/rt hazards.
// Optional forwarding ports fwd_rs/rt_data/valid are built when REG_WB_BYPASS_EN is defined.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [4:0]               enq_rd,
  input  logic [31:0]              enq_data,
  input  logic                     alu_regwrite,
  output logic                     RegWrite,
  output logic [4:0]               rd,
  output logic [31:0]              writedata,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     hazard_rs,
  output logic                     hazard_rt,
`ifdef REG_WB_BYPASS_EN
  output logic [31:0]              fwd_rs_data,
  output logic [31:0]              fwd_rt_data,
  output logic                     fwd_rs_valid,
  output logic                     fwd_rt_valid,
`endif
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [AW-1:0]    r_head, r_tail;
  logic [AW:0]      r_count;
  logic             w_push, w_pop;
  logic [AW-1:0]    w_idx;
  assign enq_ready = r_count != (AW+1)'(DEPTH);
  assign w_push    = enq_valid && enq_ready && enq_rd != 5'd0;
  assign RegWrite  = r_count != '0 && !alu_regwrite;
  assign w_pop     = RegWrite;
  assign rd        = RegWrite ? r_rd[r_head] : 5'd0;
  assign writedata = RegWrite ? r_data[r_head] : 32'd0;
  assign count     = r_count;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_vld   <= '0;
    end else begin
      if (w_pop) r_vld[r_head] <= 1'b0;
      if (w_push) r_vld[r_tail] <= 1'b1;
      if (w_pop) r_head <= r_head + AW'(1);
      if (w_push) r_tail <= r_tail + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_rd[r_tail]   <= enq_rd;
      r_data[r_tail] <= enq_data;
    end
  // Scan oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    w_idx     = r_head;
`ifdef REG_WB_BYPASS_EN
    fwd_rs_data = 32'd0;
    fwd_rt_data = 32'd0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_head + AW'(k);
      if (r_vld[w_idx] && rs != 5'd0 && r_rd[w_idx] == rs) begin
        hazard_rs = 1'b1;
`ifdef REG_WB_BYPASS_EN
        fwd_rs_data = r_data[w_idx];
`endif
      end
      if (r_vld[w_idx] && rt != 5'd0 && r_rd[w_idx] == rt) begin
        hazard_rt = 1'b1;
`ifdef REG_WB_BYPASS_EN
        fwd_rt_data = r_data[w_idx];
`endif
      end
    end
  end
`ifdef REG_WB_BYPASS_EN
  assign fwd_rs_valid = hazard_rs;
  assign fwd_rt_valid = hazard_rt;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed and random checks of reg_writeback_queue against a queue-based reference model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  typedef struct packed {logic [4:0] rd; logic [31:0] d;} ent_t;
  logic clk = 1'b0, reset = 1'b1;
  logic enq_valid = 1'b0, alu_regwrite = 1'b0;
  logic [4:0] enq_rd = '0, rs = '0, rt = '0;
  logic [31:0] enq_data = '0;
  logic enq_ready, RegWrite, hazard_rs, hazard_rt;
  logic [4:0] rd;
  logic [31:0] writedata;
  logic [2:0] count;
`ifdef REG_WB_BYPASS_EN
  logic [31:0] fwd_rs_data, fwd_rt_data;
  logic fwd_rs_valid, fwd_rt_valid;
`endif
  int tests = 0, fails = 0;
  ent_t mq[$];
  reg_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_rd(enq_rd), .enq_data(enq_data), .alu_regwrite(alu_regwrite),
    .RegWrite(RegWrite), .rd(rd), .writedata(writedata), .rs(rs), .rt(rt),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt),
`ifdef REG_WB_BYPASS_EN
    .fwd_rs_data(fwd_rs_data), .fwd_rt_data(fwd_rt_data),
    .fwd_rs_valid(fwd_rs_valid), .fwd_rt_valid(fwd_rt_valid),
`endif
    .count(count));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    logic erw, hrs, hrt;
    logic [4:0] erd;
    logic [31:0] ed, frs, frt;
    erw = mq.size() != 0 && !alu_regwrite && !reset;
    erd = erw ? mq[0].rd : 5'd0;
    ed  = erw ? mq[0].d : 32'd0;
    {hrs, hrt, frs, frt} = '0;
    foreach (mq[i]) begin
      if (rs != 0 && mq[i].rd == rs) begin hrs = 1'b1; frs = mq[i].d; end
      if (rt != 0 && mq[i].rd == rt) begin hrt = 1'b1; frt = mq[i].d; end
    end
    chk({tag, ".RegWrite"}, RegWrite, erw);
    chk({tag, ".rd"}, rd, erd);
    chk({tag, ".writedata"}, writedata, ed);
    chk({tag, ".count"}, count, mq.size());
    chk({tag, ".enq_ready"}, enq_ready, mq.size() < DEPTH);
    chk({tag, ".hazard_rs"}, hazard_rs, hrs);
    chk({tag, ".hazard_rt"}, hazard_rt, hrt);
`ifdef REG_WB_BYPASS_EN
    chk({tag, ".fwd_rs_valid"}, fwd_rs_valid, hrs);
    chk({tag, ".fwd_rt_valid"}, fwd_rt_valid, hrt);
    chk({tag, ".fwd_rs_data"}, fwd_rs_data, frs);
    chk({tag, ".fwd_rt_data"}, fwd_rt_data, frt);
`else
    if (frs != frt) chk({tag, ".unused"}, 32'd0, 32'd0);
`endif
  endtask
  task automatic drive(input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                       input logic alu, input logic [4:0] irs, input logic [4:0] irt);
    enq_valid = ev; enq_rd = erd; enq_data = ed; alu_regwrite = alu; rs = irs; rt = irt;
    #1;
  endtask
  task automatic tick();
    bit push, pop;
    ent_t dummy;
    push = enq_valid && mq.size() < DEPTH && enq_rd != 0;
    pop  = mq.size() != 0 && !alu_regwrite;
    @(posedge clk);
    if (!reset) begin
      if (pop) dummy = mq.pop_front();
      if (push) mq.push_back('{rd: enq_rd, d: enq_data});
    end
    #1;
  endtask
  task automatic step(input string tag, input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                      input logic alu, input logic [4:0] irs, input logic [4:0] irt);
    drive(ev, erd, ed, alu, irs, irt);
    check_all(tag);
    tick();
  endtask
  initial begin
    tick();
    tick();
    #2 reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    check_all("reset");
    chk("reset.count0", count, 0);
    chk("reset.ready1", enq_ready, 1);
    tick();
    // Single entry drains the cycle after it is accepted.
    step("t1.enq", 1, 5, 32'hDEADBEEF, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("t1.rw", RegWrite, 1);
    chk("t1.rd", rd, 5);
    chk("t1.data", writedata, 32'hDEADBEEF);
    chk("t1.cnt1", count, 1);
    check_all("t1.drain");
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t1.rw0", RegWrite, 0);
    chk("t1.cnt0", count, 0);
    tick();
    // Fill under ALU stall, reject a fifth, then drain in order.
    for (int i = 1; i <= 4; i++) step("t2.fill", 1, 5'(i), 32'(i * 'h11), 1, 0, 0);
    drive(1, 5, 32'h55, 1, 0, 0);
    chk("t2.full_ready", enq_ready, 0);
    chk("t2.full_cnt", count, 4);
    chk("t2.full_rw", RegWrite, 0);
    check_all("t2.full");
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      chk("t2.order_rd", rd, 5'(i));
      chk("t2.order_rw", RegWrite, 1);
      check_all("t2.drain");
      tick();
    end
    // rd == 0 handshakes but stores nothing.
    drive(1, 0, 32'h1234, 0, 0, 0);
    chk("t3.ready", enq_ready, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("t3.cnt", count, 0);
    chk("t3.rw", RegWrite, 0);
    tick();
    // Hazard on stalled entry persists through its pop cycle.
    step("t4.enq", 1, 7, 32'h77, 1, 7, 0);
    drive(0, 0, 0, 1, 7, 0);
    chk("t4.hz_rs", hazard_rs, 1);
    chk("t4.hz_rt", hazard_rt, 0);
    tick();
    drive(0, 0, 0, 0, 7, 0);
    chk("t4.hz_popcycle", hazard_rs, 1);
    tick();
    drive(0, 0, 0, 0, 7, 0);
    chk("t4.hz_after", hazard_rs, 0);
    tick();
    // Async reset with pending entries.
    for (int i = 0; i < 3; i++) step("t5.enq", 1, 5'(10 + i), 32'(i), 1, 10, 11);
    #2 reset = 1'b1;
    #1;
    mq.delete();
    chk("t5.cnt", count, 0);
    chk("t5.rw", RegWrite, 0);
    chk("t5.hz_rs", hazard_rs, 0);
    chk("t5.hz_rt", hazard_rt, 0);
    tick();
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) step("t5.post", 0, 0, 0, 0, 10, 12);
`ifdef REG_WB_BYPASS_EN
    step("t6.a", 1, 9, 32'hA, 1, 9, 0);
    step("t6.b", 1, 9, 32'hB, 1, 9, 0);
    drive(0, 0, 0, 1, 9, 0);
    chk("t6.fwd_valid", fwd_rs_valid, 1);
    chk("t6.fwd_data", fwd_rs_data, 32'hB);
    tick();
    for (int i = 0; i < 3; i++) step("t6.drain", 0, 0, 0, 0, 9, 0);
`endif
    // Random traffic against the model, with one async reset partway.
    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 reset = 1'b1;
        #1;
        mq.delete();
        check_all("rand.reset");
        tick();
        #2 reset = 1'b0;
      end
      step("rand", 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 9) < 3, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg_writeback_queue.md
Name: reg_writeback_queue

Overview:
- Writer-side companion to the register file: buffers register write-backs from multi-cycle producers (load unit, mul/div) and drives the file's single write port (RegWrite, rd, writedata).
- Yields the write port to the single-cycle ALU path whenever that path writes.
- Provides scoreboard hazard flags for the rs/rt being decoded, so the control unit stalls instead of reading stale operands.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- enq_valid  input  1  producer has a write-back to queue.
- enq_ready  output  1  queue can accept; equals (count < DEPTH).
- enq_rd  input  5  destination register of the queued write.
- enq_data  input  32  value to write.
- alu_regwrite  input  1  ALU path owns the register file write port this cycle.
- RegWrite  output  1  write enable to register file (queue's contribution; top level ORs/muxes with the ALU path).
- rd  output  5  write address to register file.
- writedata  output  32  write data to register file.
- rs  input  5  decode-stage source register 1.
- rt  input  5  decode-stage source register 2.
- hazard_rs  output  1  a pending queued write targets rs.
- hazard_rt  output  1  a pending queued write targets rt.
- count  output  AW+1  number of stored entries, 0..DEPTH.

Behaviour:
- Reset (async, active-high): head/tail pointers = 0, count = 0, all entry valid bits = 0. RegWrite = 0, hazard_rs = hazard_rt = 0, enq_ready = 1. Entry data contents are don't-care.
- Reset asserted mid-operation: all pending writes are discarded. No RegWrite pulse occurs while reset is high.
- Storage: circular buffer of {rd[4:0], data[31:0]}. Pointers wrap modulo DEPTH.
- Enqueue fires when enq_valid && enq_ready at a rising edge. The entry is written at tail; tail increments.
- enq_rd == 0: the handshake completes but nothing is stored. Count and tail are unchanged, since $zero is never written.
- Full (count == DEPTH): enq_ready = 0. There is no pass-through, even if a pop occurs in the same cycle.
- Drain is combinational from head:
  - RegWrite = (count != 0) && !alu_regwrite.
  - rd / writedata = head entry; both are 0 when RegWrite = 0.
- Pop fires at the rising edge where RegWrite = 1: head increments and count decrements.
- Latency: an entry accepted at edge N appears at head after edge N. It writes the register file at edge N+1 if unblocked and the queue was empty; otherwise it waits its FIFO turn.
- alu_regwrite = 1: the queue holds. No pop occurs and the head is unchanged. Stall may continue indefinitely.
- Simultaneous enqueue and pop: count unchanged; both pointers advance.
- Write order to the register file equals enqueue order, including multiple entries with the same rd (last one wins in the file).
- hazard_rs = 1 iff rs != 0 and any stored entry has rd == rs. hazard_rt is the same for rt.
  - Purely combinational over stored entries only; the entry being enqueued this cycle is not included.
  - The head entry being popped this cycle still counts as a hazard this cycle (the register file is not yet updated).
- count is a registered value, consistent with the pointer state.

Optional Feature:
- Macro: REG_WB_BYPASS_EN.
- Defined: adds output ports fwd_rs_data[31:0], fwd_rt_data[31:0], fwd_rs_valid, fwd_rt_valid.
  - fwd_x_valid = hazard_x.
  - fwd_x_data = data of the youngest stored entry whose rd matches (closest to tail); 0 when no match.
  - Allows the control unit to forward instead of stall.
- Undefined: these ports and their logic do not exist. Hazards are reported only via hazard_rs/hazard_rt.

Test Plan:
- Reset, then enqueue {rd=5, data=0xDEADBEEF} with alu_regwrite=0. Required: the next cycle has RegWrite=1, rd=5, writedata=0xDEADBEEF for exactly one cycle; count goes 1 -> 0.
- Hold alu_regwrite=1 and enqueue 4 entries (rd=1..4, data=0x11..0x44). Required: count=4, enq_ready=0, RegWrite=0 throughout; a 5th enq_valid is not accepted. Release alu_regwrite. Required: four consecutive writes in order rd 1,2,3,4.
- Enqueue rd=0 data=0x1234. Required: handshake completes, count stays 0, no RegWrite pulse.
- Queue holds rd=7 (stalled). Drive rs=7, rt=0. Required: hazard_rs=1, hazard_rt=0. After the entry pops, hazard_rs=0 in the following cycle.
- With 3 entries pending, assert reset asynchronously mid-cycle. Required: count=0, RegWrite=0, hazards=0 immediately. After release, no stale writes ever appear.
- REG_WB_BYPASS_EN: enqueue rd=9/0xA, then rd=9/0xB with alu_regwrite=1, and set rs=9. Required: fwd_rs_valid=1, fwd_rs_data=0xB.
